traffic_sensor_conditioner: RTL and testbench
=============================================

# traffic_sensor_conditioner

Conditions the two raw vehicle-loop detector inputs of the intersection and produces the clean presence requests `t_a` / `t_b` consumed by the traffic-light controller FSM. Each channel is synchronised, debounced and held for a gap-extension time after the vehicle leaves. A channel whose detector stays occupied too long is declared faulty, so a stuck loop cannot hold one street green indefinitely.

## Interface
- `DEB_CYCLES`, 4: consecutive stable synchronised samples required before the filtered level changes (≥2).
- `HOLD_CYCLES`, 8: gap-extension cycles `t_x` stays high after the filtered detector drops (≥1).
- `MAX_CYCLES`, 1024: continuous occupied cycles in PRESENT before the channel is declared faulty (≥2).

- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `det_a`  in  1  raw detector, street A, asynchronous to `clock`.
- `det_b`  in  1  raw detector, street B, asynchronous to `clock`.
- `t_a`    out 1  conditioned presence request, street A, registered.
- `t_b`    out 1  conditioned presence request, street B, registered.
- `fault_a` out 1  street A detector declared stuck, registered.
- `fault_b` out 1  street B detector declared stuck, registered.

## Operation
- Channels A and B are identical and fully independent. Simultaneous events on both are handled in parallel with no interaction.
- Synchroniser: two flops, `sync1 <= det`, `sync2 <= sync1`.
- Debounce: register `filt` plus counter `deb_cnt`, width `$clog2(DEB_CYCLES)`.
  - While `sync2 != filt`: increment `deb_cnt`. When `deb_cnt == DEB_CYCLES-1`, set `filt <= sync2` and `deb_cnt <= 0`.
  - While `sync2 == filt`: `deb_cnt <= 0`. A pulse shorter than `DEB_CYCLES` samples never reaches `filt`.
- Channel FSM, 2-bit states:
  - IDLE: `t=0`, `fault=0`. Goes to PRESENT if `filt=1`; presence counter cleared to 0.
  - PRESENT: `t=1`, `fault=0`. Presence counter increments each cycle.
    - `filt=0` → EXTEND, hold counter cleared.
    - Else counter reaching `MAX_CYCLES-1` → FAULT.
  - EXTEND: `t=1`, `fault=0`. Presence counter holds its value; hold counter increments.
    - `filt=1` → PRESENT, presence count not cleared, so a chattering detector is still caught.
    - Else hold counter reaching `HOLD_CYCLES-1` → IDLE.
  - FAULT: `t=0`, `fault=1`. Goes to IDLE when `filt=0`, with no extension.
- Outputs decode from the state register (Moore). Illegal state encodings go to IDLE.
- Counter widths: `$clog2(MAX_CYCLES)` and `$clog2(HOLD_CYCLES)`, minimum 1 bit. Counters saturate at their terminal value and never wrap.

## Timing
- Reset (`reset=0`, asynchronous) clears, on both channels:
  - all flops: sync, `filt`, counters;
  - state to IDLE;
  - `t_a = t_b = fault_a = fault_b = 0`.
- Reset asserted mid-operation aborts immediately. After release, a still-high detector incurs the full rise latency again.
- Edges below are counted from the first rising edge that samples a new stable `det` level as edge 1.
- Rise latency: `filt` changes at edge `DEB_CYCLES+2` and `t` rises at edge `DEB_CYCLES+3` (edge 7 with defaults).
- Fall latency: `t` falls at edge `DEB_CYCLES+3+HOLD_CYCLES` (edge 15 with defaults), provided `det` stays low.
- A detector re-rise whose `filt` rise lands while in EXTEND keeps `t` continuously high, with no low gap.
- Fault: `fault` rises, and `t` falls in the same cycle, `MAX_CYCLES` edges after PRESENT is entered, counting only cycles spent in PRESENT.

## Structure
- Shared package `traffic_pkg` holds:
  - `typedef enum logic [1:0] {SENSE_IDLE, SENSE_PRESENT, SENSE_EXTEND, SENSE_FAULT} sense_state_t`;
  - the lamp colour constants (`RED=2'b00`, `YELLOW=2'b01`, `GREEN=2'b10`) used by the controller.
- Sub-module `sensor_channel` contains the synchroniser, debounce and FSM for one detector. The top instantiates it twice and passes the parameters through.

## Test plan
- Reset, then `det_a` held high from edge 1 → `t_a` low through edge 6 and high from edge 7; `t_b`, `fault_*` remain 0.
- 3-cycle high pulse on `det_b` with `DEB_CYCLES=4` → `t_b` never rises, `deb_cnt` returns to 0.
- `det_a` high for 20 cycles, then low → `t_a` stays high 8 cycles past the `filt` fall, then drops at fall edge 15. Repeat, re-raising `det_a` 3 cycles after `filt` falls → `t_a` never drops.
- `MAX_CYCLES=16`, `det_b` held high → `t_b` high for 16 cycles then low with `fault_b=1`. Release `det_b` → `fault_b` clears `DEB_CYCLES+3` edges later and `t_b` stays 0.
- Both detectors toggled simultaneously with identical patterns → `t_a==t_b` and `fault_a==fault_b` every cycle.
- Assert `reset` asynchronously mid-EXTEND → all outputs 0 immediately, without waiting for a clock edge. Release with `det_a` high → `t_a` rises at edge 7 after release.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_pkg : shared types and constants for the intersection controller
// Revision    : 1.0
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    SENSE_IDLE    = 2'b00,
    SENSE_PRESENT = 2'b01,
    SENSE_EXTEND  = 2'b10,
    SENSE_FAULT   = 2'b11
  } sense_state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/sensor_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sensor_channel : sync + debounce + presence/extend/fault FSM, one detector
// Revision       : 1.0
// ---------------------------------------------------------------------------
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_CYCLES  = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic det,
  output logic t,
  output logic fault
);

  localparam int DW = cnt_width(DEB_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int PW = cnt_width(MAX_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PRES_LAST = PW'(MAX_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [PW-1:0] pres_cnt_q, pres_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  sense_state_t  state_q, state_d;
  logic          t_q, t_d;
  logic          fault_q, fault_d;

  always_comb begin
    sync1_d   = det;
    sync2_d   = sync1_q;
    filt_d    = filt_q;
    deb_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        filt_d    = sync2_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pres_cnt_d = pres_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      SENSE_IDLE: begin
        pres_cnt_d = '0;
        hold_cnt_d = '0;
        if (filt_q) begin
          state_d = SENSE_PRESENT;
        end
      end
      SENSE_PRESENT: begin
        // Every PRESENT cycle counts towards the fault limit, including the last.
        if (pres_cnt_q != PRES_LAST) begin
          pres_cnt_d = pres_cnt_q + PW'(1);
        end
        if (!filt_q) begin
          state_d    = SENSE_EXTEND;
          hold_cnt_d = '0;
        end else if (pres_cnt_q == PRES_LAST) begin
          state_d = SENSE_FAULT;
        end
      end
      SENSE_EXTEND: begin
        if (filt_q) begin
          state_d = SENSE_PRESENT;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = SENSE_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      SENSE_FAULT: begin
        if (!filt_q) begin
          state_d = SENSE_IDLE;
        end
      end
      default: begin
        state_d = SENSE_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they track state_q exactly.
    t_d     = (state_d == SENSE_PRESENT) || (state_d == SENSE_EXTEND);
    fault_d = (state_d == SENSE_FAULT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      filt_q     <= 1'b0;
      deb_cnt_q  <= '0;
      pres_cnt_q <= '0;
      hold_cnt_q <= '0;
      state_q    <= SENSE_IDLE;
      t_q        <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      deb_cnt_q  <= deb_cnt_d;
      pres_cnt_q <= pres_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      t_q        <= t_d;
      fault_q    <= fault_d;
    end
  end

  assign t     = t_q;
  assign fault = fault_q;

endmodule : sensor_channel
`default_nettype wire

// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// traffic_sensor_conditioner : two independent loop-detector conditioners
// Revision                   : 1.0
// ---------------------------------------------------------------------------
module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int MAX_CYCLES  = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic det_a,
  input  logic det_b,
  output logic t_a,
  output logic t_b,
  output logic fault_a,
  output logic fault_b
);

  sensor_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_chan_a (
    .clock(clock),
    .reset(reset),
    .det  (det_a),
    .t    (t_a),
    .fault(fault_a)
  );

  sensor_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_chan_b (
    .clock(clock),
    .reset(reset),
    .det  (det_b),
    .t    (t_b),
    .fault(fault_b)
  );

endmodule : traffic_sensor_conditioner
`default_nettype wire

// File: tb/tb_traffic_sensor_conditioner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_traffic_sensor_conditioner : directed + random bench with a reference model
// Revision                      : 1.0
// ---------------------------------------------------------------------------
module tb_traffic_sensor_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic det_a = 1'b0, det_b = 1'b0, det_fa = 1'b0, det_fb = 1'b0;
  logic t_a, t_b, fault_a, fault_b;
  logic t_fa, t_fb, fault_fa, fault_fb;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  traffic_sensor_conditioner u_dut (
    .clock  (clock),
    .reset  (reset),
    .det_a  (det_a),
    .det_b  (det_b),
    .t_a    (t_a),
    .t_b    (t_b),
    .fault_a(fault_a),
    .fault_b(fault_b)
  );

  traffic_sensor_conditioner #(.MAX_CYCLES(16)) u_dut_f (
    .clock  (clock),
    .reset  (reset),
    .det_a  (det_fa),
    .det_b  (det_fb),
    .t_a    (t_fa),
    .t_b    (t_fb),
    .fault_a(fault_fa),
    .fault_b(fault_fb)
  );

  // Reference model: channels 0/1 = u_dut A/B, 2/3 = u_dut_f A/B.
  // mode: 0 idle, 1 occupied, 2 gap-extension, 3 stuck.
  int   maxc [4] = '{1024, 1024, 16, 16};
  logic m_s1 [4];
  logic m_s2 [4];
  logic m_filt [4];
  int   m_run [4];
  int   m_mode [4];
  int   m_occ [4];
  int   m_gap [4];

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_filt[c] = 1'b0;
      m_run[c] = 0; m_mode[c] = 0; m_occ[c] = 0; m_gap[c] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] d);
    logic f_old;
    if (!reset) begin
      model_clear();
      return;
    end
    for (int c = 0; c < 4; c++) begin
      f_old = m_filt[c];
      case (m_mode[c])
        0: if (f_old) begin m_mode[c] = 1; m_occ[c] = 0; end
        1: begin
          m_occ[c] = m_occ[c] + 1;
          if (!f_old) begin m_mode[c] = 2; m_gap[c] = 0; end
          else if (m_occ[c] >= maxc[c]) m_mode[c] = 3;
        end
        2: begin
          if (f_old) m_mode[c] = 1;
          else begin
            m_gap[c] = m_gap[c] + 1;
            if (m_gap[c] >= HOLD) m_mode[c] = 0;
          end
        end
        default: if (!f_old) m_mode[c] = 0;
      endcase
      if (m_s2[c] != m_filt[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] >= DEB) begin m_filt[c] = m_s2[c]; m_run[c] = 0; end
      end else begin
        m_run[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = d[c];
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic m_t(input int c);
    return (m_mode[c] == 1) || (m_mode[c] == 2);
  endfunction

  function automatic logic m_f(input int c);
    return m_mode[c] == 3;
  endfunction

  task automatic check_all();
    check_bit("t_a",      t_a,      m_t(0));
    check_bit("t_b",      t_b,      m_t(1));
    check_bit("fault_a",  fault_a,  m_f(0));
    check_bit("fault_b",  fault_b,  m_f(1));
    check_bit("f16_t_a",  t_fa,     m_t(2));
    check_bit("f16_t_b",  t_fb,     m_t(3));
    check_bit("f16_flt_a", fault_fa, m_f(2));
    check_bit("f16_flt_b", fault_fb, m_f(3));
  endtask

  // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
  task automatic tick(input logic [3:0] d);
    det_a = d[0]; det_b = d[1]; det_fa = d[2]; det_fb = d[3];
    @(posedge clock);
    model_step(d);
    @(negedge clock);
    cyc++;
    check_all();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(4'b0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [3:0] lvl;
    int         rem [4];
    logic       shared;
    int         srem;

    model_clear();
    @(negedge clock);
    idle_ticks(3);
    reset = 1'b1;

    // Rise latency on A.
    for (int i = 1; i <= 20; i++) begin
      tick(4'b0001);
      if (i == 6) check_bit("rise_e6", t_a, 1'b0);
      if (i == 7) check_bit("rise_e7", t_a, 1'b1);
    end
    // Fall latency with gap extension.
    for (int i = 1; i <= 20; i++) begin
      tick(4'b0000);
      if (i == 14) check_bit("fall_e14", t_a, 1'b1);
      if (i == 15) check_bit("fall_e15", t_a, 1'b0);
    end

    // Short glitch on B must be filtered out.
    for (int i = 0; i < 3; i++) tick(4'b0010);
    for (int i = 1; i <= 10; i++) begin
      tick(4'b0000);
      check_bit("glitch_t_b", t_b, 1'b0);
    end
    check_bit("deb_b_zero", u_dut.u_chan_b.deb_cnt_q == '0, 1'b1);

    // Re-rise during extension keeps t_a high without a gap.
    for (int i = 0; i < 20; i++) tick(4'b0001);
    for (int i = 0; i < 8; i++) tick(4'b0000);
    for (int i = 0; i < 20; i++) begin
      tick(4'b0001);
      check_bit("no_gap", t_a, 1'b1);
    end
    idle_ticks(20);

    // Stuck detector on the MAX_CYCLES=16 instance, channel B.
    for (int i = 1; i <= 30; i++) begin
      tick(4'b1000);
      if (i == 22) begin
        check_bit("flt_e22_t", t_fb, 1'b1);
        check_bit("flt_e22_f", fault_fb, 1'b0);
      end
      if (i == 23) begin
        check_bit("flt_e23_t", t_fb, 1'b0);
        check_bit("flt_e23_f", fault_fb, 1'b1);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      tick(4'b0000);
      if (i == 6) check_bit("flt_rel6", fault_fb, 1'b1);
      if (i == 7) check_bit("flt_rel7", fault_fb, 1'b0);
      check_bit("flt_rel_t", t_fb, 1'b0);
    end

    // Stuck detector at the default limit, channel A.
    for (int i = 1; i <= 1040; i++) begin
      tick(4'b0001);
      if (i == 1030) check_bit("flt1024_pre", fault_a, 1'b0);
      if (i == 1031) check_bit("flt1024_hit", fault_a, 1'b1);
    end
    idle_ticks(20);

    // Asynchronous reset in the middle of the gap extension.
    for (int i = 0; i < 12; i++) tick(4'b0101);
    for (int i = 0; i < 10; i++) tick(4'b0000);
    check_bit("pre_rst_t_a", t_a, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_bit("arst_t_a", t_a, 1'b0);
    check_bit("arst_t_b", t_b, 1'b0);
    check_bit("arst_f_a", fault_a, 1'b0);
    check_bit("arst_f_b", fault_b, 1'b0);
    check_bit("arst_t_fa", t_fa, 1'b0);
    check_bit("arst_f_fb", fault_fb, 1'b0);
    model_clear();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(4'b0001);
      if (i == 6) check_bit("rel_e6", t_a, 1'b0);
      if (i == 7) check_bit("rel_e7", t_a, 1'b1);
    end
    idle_ticks(20);

    // Random, independent channels.
    lvl = 4'b0000;
    for (int c = 0; c < 4; c++) rem[c] = 1;
    for (int n = 0; n < 900; n++) begin
      for (int c = 0; c < 4; c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          lvl[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 40))
                                                : int'($urandom_range(1, 14));
        end
      end
      tick(lvl);
    end

    // Random, identical pattern on every channel.
    shared = 1'b0;
    srem   = 1;
    for (int n = 0; n < 500; n++) begin
      srem--;
      if (srem <= 0) begin
        shared = ~shared;
        srem   = int'($urandom_range(1, 24));
      end
      tick({4{shared}});
    end
    idle_ticks(25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_traffic_sensor_conditioner
`default_nettype wire
